// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 core datapath.
// Contents: register index constants, datapath widths and the
// writeback source select type.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_t;

endpackage

// File: rtl/regfile_array.sv
// Register file storage: NREGS x DATA_W, one synchronous write port,
// two asynchronous read ports, synchronous active-low clear.
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low clear of every entry
//   we             write enable
//   waddr, wdata   write address / data
//   raddr_a/b      read addresses
//   rdata_a/b      read data (combinational, raw array contents)
module regfile_array #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: consumer end of the MEM/WB pipeline register.
// Selects the writeback value, commits it to the register file, serves
// the two ID read ports with write-through bypass and counts commits.
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   read_data_in              load data from MEM/WB
//   alu_result_in             ALU result / link address from MEM/WB
//   dest_in                   destination register
//   reg_write_in              write enable from MEM/WB
//   jump_in                   jump flag (forces ALU/link value)
//   mem_to_reg_in             1 = load data, 0 = ALU result
//   rs_addr, rt_addr          ID read addresses
//   rs_data, rt_data          ID read data (combinational)
//   wb_data, wb_we, wb_dest   committed write, to forwarding (combinational)
//   wb_count                  number of committed writes (registered, wraps)
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     read_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  reg_write_in,
  input  logic                  jump_in,
  input  logic                  mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [CNT_W-1:0]      wb_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wb_sel_t           wb_sel;
  logic [DATA_W-1:0] arr_rs;
  logic [DATA_W-1:0] arr_rt;

  // Jump writes the link address carried on the ALU path, so it wins
  // over mem_to_reg.
  assign wb_sel  = (jump_in || !mem_to_reg_in) ? WB_ALU : WB_MEM;
  assign wb_data = (wb_sel == WB_MEM) ? read_data_in : alu_result_in;

  // Folding rst_n in keeps a pending write out of the bypass during reset.
  assign wb_we   = rst_n & reg_write_in & (dest_in != REG_ZERO);
  assign wb_dest = dest_in;

  regfile_array #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (REG_ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we),
    .waddr   (dest_in),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (arr_rs),
    .rdata_b (arr_rt)
  );

  always_comb begin
    rs_data = arr_rs;
    if (rs_addr == REG_ZERO) begin
      rs_data = '0;
    end else if (wb_we && (rs_addr == dest_in)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = arr_rt;
    if (rt_addr == REG_ZERO) begin
      rt_data = '0;
    end else if (wb_we && (rt_addr == dest_in)) begin
      rt_data = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (wb_we) begin
      wb_count <= wb_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  dest_in;
  logic        reg_write_in;
  logic        jump_in;
  logic        mem_to_reg_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_count;

  logic [31:0] rs_data4, rt_data4, wb_data4;
  logic        wb_we4;
  logic [4:0]  wb_dest4;
  logic [3:0]  wb_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .dest_in(dest_in), .reg_write_in(reg_write_in),
    .jump_in(jump_in), .mem_to_reg_in(mem_to_reg_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_we(wb_we), .wb_dest(wb_dest),
    .wb_count(wb_count)
  );

  // Narrow-counter build sharing the same stimulus, for wrap checking.
  wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .dest_in(dest_in), .reg_write_in(reg_write_in),
    .jump_in(jump_in), .mem_to_reg_in(mem_to_reg_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data4), .rt_data(rt_data4),
    .wb_data(wb_data4), .wb_we(wb_we4), .wb_dest(wb_dest4),
    .wb_count(wb_count4)
  );

  task automatic commit(input logic [4:0] dest, input logic [31:0] alu,
                        input logic [31:0] rd, input logic mtr, input logic jmp);
    @(negedge clk);
    dest_in       = dest;
    alu_result_in = alu;
    read_data_in  = rd;
    mem_to_reg_in = mtr;
    jump_in       = jmp;
    reg_write_in  = 1'b1;
    @(posedge clk);
    #1;
    reg_write_in  = 1'b0;
    jump_in       = 1'b0;
    mem_to_reg_in = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      commit(5'($urandom_range(31, 1)), $urandom, $urandom, 1'($urandom), 1'b0);
    end
    do_reset(2);
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      checks++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d rs=%h rt=%h required 0", a, rs_data, rt_data);
      end
    end
    checks++;
    if (wb_count !== 32'd0 || wb_count4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d required 0", wb_count, wb_count4);
    end
  endtask

  task automatic test_alu_mem_select();
    @(negedge clk);
    dest_in = 5'd5; alu_result_in = 32'h11; read_data_in = 32'h22;
    mem_to_reg_in = 1'b0; jump_in = 1'b0; reg_write_in = 1'b1;
    #1;
    checks++;
    if (wb_data !== 32'h11 || wb_we !== 1'b1 || wb_dest !== 5'd5) begin
      errors++;
      $display("FAIL sel_alu_comb wb_data=%h we=%b dest=%0d required 11/1/5", wb_data, wb_we, wb_dest);
    end
    @(posedge clk); #1;
    reg_write_in = 1'b0;
    rs_addr = 5'd5;
    #1;
    checks++;
    if (rs_data !== 32'h11) begin
      errors++;
      $display("FAIL sel_alu_r5 got %h required 00000011", rs_data);
    end
    commit(5'd5, 32'h11, 32'h22, 1'b1, 1'b0);
    rt_addr = 5'd5;
    #1;
    checks++;
    if (rt_data !== 32'h22 || wb_count !== 32'd2) begin
      errors++;
      $display("FAIL sel_mem_r5 got %h cnt %0d required 00000022 cnt 2", rt_data, wb_count);
    end
  endtask

  task automatic test_jump();
    @(negedge clk);
    dest_in = 5'd31; alu_result_in = 32'h0040_0008; read_data_in = 32'hDEAD;
    mem_to_reg_in = 1'b1; jump_in = 1'b1; reg_write_in = 1'b1;
    #1;
    checks++;
    if (wb_data !== 32'h0040_0008) begin
      errors++;
      $display("FAIL jump_wb_data got %h required 00400008", wb_data);
    end
    @(posedge clk); #1;
    reg_write_in = 1'b0; jump_in = 1'b0; mem_to_reg_in = 1'b0;
    rt_addr = 5'd31;
    #1;
    checks++;
    if (rt_data !== 32'h0040_0008 || wb_count !== 32'd3) begin
      errors++;
      $display("FAIL jump_r31 got %h cnt %0d required 00400008 cnt 3", rt_data, wb_count);
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    dest_in = 5'd0; alu_result_in = 32'hFFFF_FFFF; read_data_in = 32'hFFFF_FFFF;
    mem_to_reg_in = 1'b0; jump_in = 1'b0; reg_write_in = 1'b1;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    checks++;
    if (wb_we !== 1'b0 || rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL r0_comb we=%b rs=%h rt=%h required 0/0/0", wb_we, rs_data, rt_data);
    end
    @(posedge clk); #1;
    reg_write_in = 1'b0;
    #1;
    checks++;
    if (rs_data !== 32'h0 || wb_count !== 32'd3) begin
      errors++;
      $display("FAIL r0_after rs=%h cnt %0d required 0 cnt 3", rs_data, wb_count);
    end
  endtask

  task automatic test_bypass();
    commit(5'd7, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    dest_in = 5'd7; alu_result_in = 32'hA5A5_A5A5; read_data_in = 32'h0;
    mem_to_reg_in = 1'b0; jump_in = 1'b0; reg_write_in = 1'b1;
    rs_addr = 5'd7; rt_addr = 5'd7;
    #1;
    checks++;
    if (rs_data !== 32'hA5A5_A5A5 || rt_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass_both rs=%h rt=%h required a5a5a5a5", rs_data, rt_data);
    end
    rt_addr = 5'd5;
    #1;
    checks++;
    if (rs_data !== 32'hA5A5_A5A5 || rt_data !== 32'h22) begin
      errors++;
      $display("FAIL bypass_one rs=%h rt=%h required a5a5a5a5/00000022", rs_data, rt_data);
    end
    rt_addr = 5'd7;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b1; jump_in = 1'b1;
    #1;
    checks++;
    if (rs_data !== 32'h1234 || rt_data !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_off rs=%h rt=%h required 00001234", rs_data, rt_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rs_data !== 32'h1234 || wb_count !== 32'd4) begin
      errors++;
      $display("FAIL nowrite_hold rs=%h cnt %0d required 00001234 cnt 4", rs_data, wb_count);
    end
    commit(5'd7, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (rt_data !== 32'hA5A5_A5A5 || wb_count !== 32'd5) begin
      errors++;
      $display("FAIL bypass_commit rt=%h cnt %0d required a5a5a5a5 cnt 5", rt_data, wb_count);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    rst_n = 1'b0;
    dest_in = 5'd3; alu_result_in = 32'h3333_3333; read_data_in = 32'h0;
    mem_to_reg_in = 1'b0; jump_in = 1'b0; reg_write_in = 1'b1;
    rs_addr = 5'd3;
    #1;
    checks++;
    if (wb_we !== 1'b0 || rs_data === 32'h3333_3333) begin
      errors++;
      $display("FAIL rst_we we=%b rs=%h required we 0, no bypass", wb_we, rs_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    reg_write_in = 1'b0;
    rt_addr = 5'd7;
    #1;
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0 || wb_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid r3=%h r7=%h cnt %0d required 0/0/0", rs_data, rt_data, wb_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      commit(5'((i % 31) + 1), 32'(i), 32'h0, 1'b0, 1'b0);
    end
    #1;
    checks++;
    if (wb_count4 !== 4'd1) begin
      errors++;
      $display("FAIL wrap_cnt4 got %0d required 1", wb_count4);
    end
    checks++;
    if (wb_count !== 32'd17) begin
      errors++;
      $display("FAIL wrap_cnt32 got %0d required 17", wb_count);
    end
    rs_addr = 5'd17;
    #1;
    checks++;
    if (rs_data !== 32'd16) begin
      errors++;
      $display("FAIL wrap_r17 got %h required 00000010", rs_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    read_data_in = '0; alu_result_in = '0; dest_in = '0;
    reg_write_in = 1'b0; jump_in = 1'b0; mem_to_reg_in = 1'b0;
    rs_addr = '0; rt_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_alu_mem_select();
    test_jump();
    test_r0();
    test_bypass();
    test_reset_mid_write();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
